// File: rtl/reg_file_sb.sv
// reg_file_sb: DEPTH x DATA_W register file for the decode stage.
//   Two combinational read ports, one write port, an optional hard-wired
//   zero register and a per-register pending-write (busy) scoreboard.
//
// Parameters: DATA_W (register width), ADDR_W (index width, DEPTH = 2**ADDR_W),
//             ZERO_R0 (1: R0 reads 0, ignores writes and issues).
// Ports:
//   Clock, Reset_n             rising-edge clock, async active-low reset
//   RS, RT                     read indices
//   ReadRS, ReadRT             read data (combinational)
//   BusyRS, BusyRT             outstanding producer on RS / RT
//   RegWrite, RD, WriteData    writeback port; clears busy[RD]
//   Issue, IssueRD             sets busy[IssueRD]; wins over a same-edge write
//   PendCount                  registered count of busy registers
//
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle writeback
// (data and cleared busy) onto the read ports. Default build reads storage only.

module reg_file_sb_rdport #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int DEPTH   = 8,
  parameter int ZERO_R0 = 1
) (
  input  logic [ADDR_W-1:0]             idx,
  input  logic [DEPTH-1:0][DATA_W-1:0]  regs,
  input  logic [DEPTH-1:0]              busyVec,
  input  logic                          bypEn,
  input  logic [ADDR_W-1:0]             wrIdx,
  input  logic [DATA_W-1:0]             wrData,
  input  logic                          issEn,
  input  logic [ADDR_W-1:0]             issIdx,
  output logic [DATA_W-1:0]             rdData,
  output logic                          rdBusy
);
  always_comb begin
    rdData = regs[idx];
    rdBusy = busyVec[idx];
    // Forwarded writeback: the result is ready now, unless a new producer
    // for the same register issues in this very cycle.
    if (bypEn && (idx == wrIdx)) begin
      rdData = wrData;
      rdBusy = issEn && (issIdx == idx);
    end
    if ((ZERO_R0 != 0) && (idx == '0)) begin
      rdData = '0;
      rdBusy = 1'b0;
    end
  end
endmodule

module reg_file_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter int ZERO_R0 = 1
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] RS,
  input  logic [ADDR_W-1:0] RT,
  output logic [DATA_W-1:0] ReadRS,
  output logic [DATA_W-1:0] ReadRT,
  output logic              BusyRS,
  output logic              BusyRT,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] RD,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              Issue,
  input  logic [ADDR_W-1:0] IssueRD,
  output logic [ADDR_W:0]   PendCount
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             busy, busyNext;
  logic [ADDR_W:0]              pendNext;
  logic                         wrOk, issOk, bypEn;
  logic [1:0][ADDR_W-1:0]       rdIdx;
  logic [1:0][DATA_W-1:0]       rdData;
  logic [1:0]                   rdBusy;

  assign wrOk  = RegWrite && !((ZERO_R0 != 0) && (RD == '0));
  assign issOk = Issue    && !((ZERO_R0 != 0) && (IssueRD == '0));

`ifdef REGFILE_BYPASS_EN
  // Gated by reset so every output reads 0 while Reset_n is low.
  assign bypEn = RegWrite && Reset_n;
`else
  assign bypEn = 1'b0;
`endif

  // Clear-then-set ordering lets a same-edge issue win over the writeback.
  always_comb begin
    busyNext = busy;
    if (wrOk)  busyNext[RD]      = 1'b0;
    if (issOk) busyNext[IssueRD] = 1'b1;
  end

  always_comb begin
    pendNext = '0;
    for (int i = 0; i < DEPTH; i++)
      pendNext = pendNext + {{ADDR_W{1'b0}}, busyNext[i]};
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      regs      <= '0;
      busy      <= '0;
      PendCount <= '0;
    end else begin
      if (wrOk) regs[RD] <= WriteData;
      busy      <= busyNext;
      PendCount <= pendNext;
    end
  end

  assign rdIdx[0] = RS;
  assign rdIdx[1] = RT;

  reg_file_sb_rdport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ZERO_R0(ZERO_R0)
  ) uRd [1:0] (
    .idx    (rdIdx),
    .regs   (regs),
    .busyVec(busy),
    .bypEn  (bypEn),
    .wrIdx  (RD),
    .wrData (WriteData),
    .issEn  (Issue),
    .issIdx (IssueRD),
    .rdData (rdData),
    .rdBusy (rdBusy)
  );

  assign ReadRS = rdData[0];
  assign ReadRT = rdData[1];
  assign BusyRS = rdBusy[0];
  assign BusyRT = rdBusy[1];
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb (default parameters). A reference model of storage
// and busy bits produces expected read-port values, which are queued when a
// read is driven and popped/compared once the outputs have settled.
module tb_reg_file_sb;
  logic        Clock, Reset_n;
  logic [2:0]  RS, RT, RD, IssueRD;
  logic [15:0] ReadRS, ReadRT, WriteData;
  logic        BusyRS, BusyRT, RegWrite, Issue;
  logic [3:0]  PendCount;

  reg_file_sb dut (
    .Clock(Clock), .Reset_n(Reset_n), .RS(RS), .RT(RT),
    .ReadRS(ReadRS), .ReadRT(ReadRT), .BusyRS(BusyRS), .BusyRT(BusyRT),
    .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
    .Issue(Issue), .IssueRD(IssueRD), .PendCount(PendCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    string       tag;
    logic [15:0] dA, dB;
    logic        bA, bB;
    logic [3:0]  pend;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] mem[8];
  logic        bsy[8];
  int          nChk = 0, nFail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] expData(input logic [2:0] idx);
    if (idx == 3'd0 || !Reset_n) return 16'h0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && RD == idx) return WriteData;
`endif
    return mem[idx];
  endfunction

  function automatic logic expBusy(input logic [2:0] idx);
    if (idx == 3'd0 || !Reset_n) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && RD == idx) return Issue && (IssueRD == idx);
`endif
    return bsy[idx];
  endfunction

  function automatic logic [3:0] expPend();
    logic [3:0] c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b0, bsy[i]};
    return c;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 8; i++) begin mem[i] = '0; bsy[i] = 1'b0; end
  endtask

  // Drive read indices, queue the expectation, then pop and compare.
  task automatic probe(input string tag, input logic [2:0] rs, input logic [2:0] rt);
    exp_t e;
    RS = rs; RT = rt;
    e.tag = tag; e.dA = expData(rs); e.dB = expData(rt);
    e.bA = expBusy(rs); e.bB = expBusy(rt); e.pend = expPend();
    sbq.push_back(e);
    #1;
    e = sbq.pop_front();
    chk({e.tag, ".rdA"}, {16'h0, ReadRS}, {16'h0, e.dA});
    chk({e.tag, ".rdB"}, {16'h0, ReadRT}, {16'h0, e.dB});
    chk({e.tag, ".bsyA"}, {31'h0, BusyRS}, {31'h0, e.bA});
    chk({e.tag, ".bsyB"}, {31'h0, BusyRT}, {31'h0, e.bB});
    chk({e.tag, ".pend"}, {28'h0, PendCount}, {28'h0, e.pend});
  endtask

  // One rising edge: model applies the driven strobes, then strobes drop.
  task automatic tick();
    @(posedge Clock);
    if (Reset_n) begin
      if (RegWrite && RD != 3'd0) begin mem[RD] = WriteData; bsy[RD] = 1'b0; end
      if (Issue && IssueRD != 3'd0) bsy[IssueRD] = 1'b1;
    end
    #2;
    RegWrite = 1'b0; Issue = 1'b0;
  endtask

  task automatic wr(input logic [2:0] rd, input logic [15:0] d);
    RegWrite = 1'b1; RD = rd; WriteData = d; tick();
  endtask

  task automatic iss(input logic [2:0] rd);
    Issue = 1'b1; IssueRD = rd; tick();
  endtask

  initial begin
    Reset_n = 1'b0; RS = '0; RT = '0; RD = '0; IssueRD = '0;
    WriteData = '0; RegWrite = 1'b0; Issue = 1'b0;
    modelReset();
    #2;
    probe("reset", 3'd3, 3'd5);
    tick(); tick();
    Reset_n = 1'b1;

    // Write / read, zero register
    wr(3'd5, 16'h1234);
    probe("wr5", 3'd5, 3'd5);
    wr(3'd0, 16'hFFFF);
    probe("wr0", 3'd0, 3'd5);
    iss(3'd0);
    probe("iss0", 3'd0, 3'd0);

    // Scoreboard set/clear
    iss(3'd2);
    iss(3'd4);
    probe("iss24", 3'd2, 3'd4);
    wr(3'd2, 16'h2222);
    probe("clr2", 3'd2, 3'd4);

    // Same-edge issue and write to R6
    RegWrite = 1'b1; RD = 3'd6; WriteData = 16'h00AA;
    Issue = 1'b1; IssueRD = 3'd6;
    tick();
    probe("simul6", 3'd6, 3'd4);

    // Same-cycle read of a register being written back
    iss(3'd7);
    RegWrite = 1'b1; RD = 3'd7; WriteData = 16'h5A5A;
    probe("byp7", 3'd7, 3'd6);
    tick();
    probe("post7", 3'd7, 3'd7);

    // Write to a non-busy register
    wr(3'd1, 16'hC0DE);
    probe("wr1", 3'd1, 3'd2);

    // Saturation
    for (int i = 1; i < 8; i++) iss(i[2:0]);
    probe("sat", 3'd3, 3'd7);
    iss(3'd3);
    probe("sat3", 3'd3, 3'd1);

    // Random traffic with reads before each edge
    for (int n = 0; n < 40; n++) begin
      RegWrite  = 1'($urandom_range(0, 1));
      RD        = 3'($urandom);
      WriteData = 16'($urandom);
      Issue     = 1'($urandom_range(0, 1));
      IssueRD   = 3'($urandom);
      probe("rnd", 3'($urandom), 3'($urandom));
      tick();
    end

    // Async reset mid-run, with a write pending across the reset edge
    wr(3'd3, 16'hBEEF);
    iss(3'd5);
    probe("beef", 3'd3, 3'd5);
    Reset_n = 1'b0;
    modelReset();
    probe("arst", 3'd3, 3'd5);
    RegWrite = 1'b1; RD = 3'd3; WriteData = 16'hBEEF;
    tick();
    Reset_n = 1'b1;
    probe("abort", 3'd3, 3'd5);
    wr(3'd3, 16'h0F0F);
    probe("rel", 3'd3, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file for the 16-bit CPU datapath with two combinational read ports, one write port, an optional hard-wired zero register and a per-register pending-write scoreboard. It replaces the fixed 8-entry file in the decode stage. Decode uses the busy flags to stall on RAW hazards, and writeback retires results into it.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, register index width; DEPTH = 2**ADDR_W entries
- ZERO_R0, 1, when 1 register 0 always reads 0, ignores writes and is never busy

Ports:
- Clock  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- RS  in  ADDR_W  read port A index
- RT  in  ADDR_W  read port B index
- ReadRS  out  DATA_W  data at RS
- ReadRT  out  DATA_W  data at RT
- BusyRS  out  1  RS has an outstanding producer
- BusyRT  out  1  RT has an outstanding producer
- RegWrite  in  1  writeback strobe
- RD  in  ADDR_W  writeback index
- WriteData  in  DATA_W  writeback data
- Issue  in  1  an instruction with a destination issues this cycle
- IssueRD  in  ADDR_W  destination of the issuing instruction
- PendCount  out  ADDR_W+1  number of busy registers

The clock is a single clock, Clock. Reset is asynchronous and active-low on Reset_n.

## Operation
- Storage is DEPTH x DATA_W. When Reset_n=0, every entry clears to 0, every busy bit clears to 0, and PendCount clears to 0. These take effect immediately, without waiting for a clock edge.
- Write: on a posedge with RegWrite=1, Registers[RD] <= WriteData. The busy bit for RD is cleared on the same edge.
- Issue: on a posedge with Issue=1, busy[IssueRD] <= 1.
- Issue and RegWrite on the same edge with IssueRD==RD: busy ends at 1, because the new producer wins. The data write still happens.
- Issue to a register that is already busy: busy stays 1 and PendCount does not change.
- RegWrite to a register that is not busy: the data is written and busy stays 0. This is legal.
- ZERO_R0=1 with index 0 on any port:
  - Writes are dropped.
  - Issue is ignored.
  - ReadRS/ReadRT return 0.
  - BusyRS/BusyRT return 0.
- Reads are combinational: ReadRS = Registers[RS] and ReadRT = Registers[RT], plus bypass (see Configuration). BusyRS = busy[RS] and BusyRT = busy[RT], plus bypass.
- PendCount is a registered population count of the busy vector, updated on the same edge as the vector. Maximum value is DEPTH, or DEPTH-1 when ZERO_R0=1.
- Out-of-range indices cannot occur, because DEPTH = 2**ADDR_W.

## Timing
- Write latency is 1 cycle: data written at edge N is visible on read ports from edge N onward.
- Busy set by Issue at edge N is visible from edge N onward.
- Read and busy outputs are purely combinational from the RS/RT indices and storage. There is no clocked read.
- Asynchronous reset during a write cycle aborts the write: the entry stays 0.
- Deassertion of Reset_n is treated as synchronous to Clock by the surrounding design. The first write takes effect at the first posedge with Reset_n=1.
- Every output reads 0 during reset.

## Configuration
- Macro REGFILE_BYPASS_EN.
- When defined, a read in the same cycle as a write returns the incoming value: if RegWrite=1 and RS==RD (and not the zero register), ReadRS = WriteData and BusyRS = 0, unless Issue targets the same register. RT behaves identically. This allows writeback and decode to overlap in one cycle.
- When undefined, reads return the stored value and the stored busy bit. A same-cycle read sees the old data and busy=1. Decode stalls one extra cycle.

## Test plan
- Reset: hold Reset_n=0 mid-run after writing R3=16'hBEEF -> ReadRS with RS=3 is 16'h0000 immediately, and PendCount=0.
- Write/read: RegWrite, RD=5, WriteData=16'h1234, then RS=5 and RT=5 next cycle -> both reads are 16'h1234. Then write RD=0, WriteData=16'hFFFF with ZERO_R0=1 -> RS=0 reads 16'h0000.
- Scoreboard: Issue with IssueRD=2, then IssueRD=4 -> PendCount=2 and BusyRS=1 with RS=2. Then RegWrite with RD=2 -> BusyRS=0 and PendCount=1.
- Simultaneous events: Issue with IssueRD=6 and RegWrite with RD=6, WriteData=16'h00AA on the same edge -> busy[6]=1 and R6 reads 16'h00AA.
- Bypass: RegWrite, RD=7, WriteData=16'h5A5A with RS=7 in the same cycle, before the edge -> ReadRS=16'h5A5A and BusyRS=0 with REGFILE_BYPASS_EN defined. Without it, ReadRS shows the old value and BusyRS shows the old busy bit.
- Saturation: issue to all 7 non-zero registers -> PendCount=7. Issue to R3 again -> PendCount stays 7.
